// File: rtl/imm_pkg.sv
// Shared immediate-select encodings for the decode stage and its bench.
// Compressed formats (IMM_CI, IMM_CJ) only decode when IMM_DECODE_RVC_EN is defined.
package imm_pkg;

    typedef logic [3:0] imm_sel_t;

    localparam imm_sel_t IMM_I     = 4'd0;
    localparam imm_sel_t IMM_S     = 4'd1;
    localparam imm_sel_t IMM_B     = 4'd2;
    localparam imm_sel_t IMM_U     = 4'd3;
    localparam imm_sel_t IMM_J     = 4'd4;
    localparam imm_sel_t IMM_SHAMT = 4'd5;
    localparam imm_sel_t IMM_ZIMM  = 4'd6;
    localparam imm_sel_t IMM_CI    = 4'd7;
    localparam imm_sel_t IMM_CJ    = 4'd8;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate extraction: instr + sel -> XLEN immediate and illegal-select flag.
// Config macro: IMM_DECODE_RVC_EN enables the CI and CJ compressed formats.
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_sel_t        sel,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Signed fields sign-extend automatically when cast up to XLEN.
    logic signed [11:0] w_i;
    logic signed [11:0] w_s;
    logic signed [12:0] w_b;
    logic signed [31:0] w_u;
    logic signed [20:0] w_j;
    logic        [5:0]  w_shamt;
    logic        [4:0]  w_zimm;
    logic               w_unused;

    assign w_i      = instr[31:20];
    assign w_s      = {instr[31:25], instr[11:7]};
    assign w_b      = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_u      = {instr[31:12], 12'b0};
    assign w_j      = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_shamt  = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    assign w_zimm   = instr[19:15];
    assign w_unused = ^instr[6:0];

`ifdef IMM_DECODE_RVC_EN
    logic signed [5:0]  w_ci;
    logic signed [11:0] w_cj;

    assign w_ci = {instr[12], instr[6:2]};
    assign w_cj = {instr[12], instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
`endif

    always_comb begin
        imm = '0;
        err = 1'b0;
        case (sel)
            IMM_I:     imm = XLEN'(w_i);
            IMM_S:     imm = XLEN'(w_s);
            IMM_B:     imm = XLEN'(w_b);
            IMM_U:     imm = XLEN'(w_u);
            IMM_J:     imm = XLEN'(w_j);
            IMM_SHAMT: imm = XLEN'(w_shamt);
            IMM_ZIMM:  imm = XLEN'(w_zimm);
`ifdef IMM_DECODE_RVC_EN
            IMM_CI:    imm = XLEN'(w_ci);
            IMM_CJ:    imm = XLEN'(w_cj);
`endif
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: combinational format extraction feeding a 2-entry in-order result buffer.
// Config macro: IMM_DECODE_RVC_EN (forwarded to imm_format) adds the CI/CJ formats.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  imm_sel_t         in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    logic             w_accept;
    logic             w_consume;

    logic [1:0]       r_cnt;
    logic [XLEN-1:0]  r_imm [2];
    logic [TAG_W-1:0] r_tag [2];
    logic             r_err [2];

    imm_format #(.XLEN(XLEN)) u_imm_format (
        .instr (in_instr),
        .sel   (in_sel),
        .imm   (w_imm),
        .err   (w_err)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready; ready comes only from r_cnt.
    assign in_ready  = (r_cnt < 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    assign out_imm = out_valid ? r_imm[0] : '0;
    assign out_tag = out_valid ? r_tag[0] : '0;
    assign out_err = out_valid ? r_err[0] : 1'b0;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_imm[i] <= '0;
                r_tag[i] <= '0;
                r_err[i] <= 1'b0;
            end
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_accept) begin
                        r_imm[0] <= w_imm;
                        r_tag[0] <= in_tag;
                        r_err[0] <= w_err;
                        r_cnt    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_accept && w_consume) begin
                        r_imm[0] <= w_imm;
                        r_tag[0] <= in_tag;
                        r_err[0] <= w_err;
                    end else if (w_consume) begin
                        r_cnt <= 2'd0;
                    end else if (w_accept) begin
                        r_imm[1] <= w_imm;
                        r_tag[1] <= in_tag;
                        r_err[1] <= w_err;
                        r_cnt    <= 2'd2;
                    end
                end
                default: begin
                    if (w_consume) begin
                        r_imm[0] <= r_imm[1];
                        r_tag[0] <= r_tag[1];
                        r_err[0] <= r_err[1];
                        r_cnt    <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench for imm_decode_stage (XLEN=32 instance plus an XLEN=64 instance).
// CI/CJ expectations follow IMM_DECODE_RVC_EN exactly as the design build does.
module tb_imm_decode_stage;
    import imm_pkg::*;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    imm_sel_t         in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    logic             d64_in_valid;
    logic             d64_in_ready;
    logic [31:0]      d64_in_instr;
    imm_sel_t         d64_in_sel;
    logic [TAG_W-1:0] d64_in_tag;
    logic             d64_out_valid;
    logic [63:0]      d64_out_imm;
    logic [TAG_W-1:0] d64_out_tag;
    logic             d64_out_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [TAG_W-1:0] exp_q[$];

    imm_decode_stage #(.XLEN(32), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_sel    (in_sel),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d64_in_valid),
        .in_ready  (d64_in_ready),
        .in_instr  (d64_in_instr),
        .in_sel    (d64_in_sel),
        .in_tag    (d64_in_tag),
        .out_valid (d64_out_valid),
        .out_ready (1'b1),
        .out_imm   (d64_out_imm),
        .out_tag   (d64_out_tag),
        .out_err   (d64_out_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input imm_sel_t sel, input logic [31:0] instr, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_sel   = sel;
        in_instr = instr;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        n_checks++; if (out_imm !== 32'h0) begin n_errors++; $display("FAIL reset_out_imm: got %h exp 0", out_imm); end
        n_checks++; if (out_tag !== '0) begin n_errors++; $display("FAIL reset_out_tag: got %h exp 0", out_tag); end
        n_checks++; if (out_err !== 1'b0) begin n_errors++; $display("FAIL reset_out_err: got %b exp 0", out_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_i_format();
        out_ready = 1'b1;
        drive_req(IMM_I, 32'hFFF00093, 5'd5);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL i_valid: got %b exp 1", out_valid); end
        n_checks++; if (out_imm !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL i_imm: got %h exp FFFFFFFF", out_imm); end
        n_checks++; if (out_err !== 1'b0) begin n_errors++; $display("FAIL i_err: got %b exp 0", out_err); end
        n_checks++; if (out_tag !== 5'd5) begin n_errors++; $display("FAIL i_tag: got %h exp 05", out_tag); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL i_drained: got %b exp 0", out_valid); end
        n_checks++; if (out_imm !== 32'h0) begin n_errors++; $display("FAIL i_idle_imm: got %h exp 0", out_imm); end
    endtask

    task automatic test_back_to_back();
        imm_sel_t    sels  [8] = '{IMM_S, IMM_B, IMM_U, IMM_J, IMM_I, IMM_SHAMT, IMM_ZIMM, IMM_S};
        logic [31:0] instrs[8] = '{32'hFE20AE23, 32'hFE000EE3, 32'h123450B7, 32'h0080006F,
                                   32'h7FF00093, 32'h03F00013, 32'hFFFFFFFF, 32'h00000F80};
        logic [31:0] exps  [8] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h00000008,
                                   32'h000007FF, 32'h0000001F, 32'h0000001F, 32'h0000001F};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_req(sels[i], instrs[i], TAG_W'(i + 10));
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_imm !== exps[i] || out_err !== 1'b0 || out_tag !== TAG_W'(i + 10)) begin
                n_errors++;
                $display("FAIL b2b_%0d: got v=%b imm=%h err=%b tag=%h exp v=1 imm=%h err=0 tag=%h",
                         i, out_valid, out_imm, out_err, out_tag, exps[i], TAG_W'(i + 10));
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        exp_q = {5'd1, 5'd2, 5'd3};
        drive_req(IMM_I, 32'h00100093, 5'd1);
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_occ1: got %b exp 1", in_ready); end
        drive_req(IMM_I, 32'h00200093, 5'd2);
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_full: got %b exp 0", in_ready); end
        drive_req(IMM_I, 32'h00300093, 5'd3);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_imm !== 32'h1 || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b tag=%h imm=%h exp rdy=0 v=1 tag=01 imm=1",
                         c, in_ready, out_valid, out_tag, out_imm);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                n_checks++;
                if (out_tag !== exp_q[0] || out_imm !== 32'(exp_q[0])) begin
                    n_errors++;
                    $display("FAIL bp_order: got tag=%h imm=%h exp tag=%h", out_tag, out_imm, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL bp_drain_timeout: got %0d left exp 0", exp_q.size()); end
        n_checks++; if (out_valid !== 1'b0 || out_tag !== '0) begin n_errors++; $display("FAIL bp_empty: got v=%b tag=%h exp v=0 tag=00", out_valid, out_tag); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive_req(4'hF, 32'hFFFFFFFF, 5'd4);
        tick();
        n_checks++; if (out_err !== 1'b1 || out_imm !== 32'h0) begin n_errors++; $display("FAIL illegal_f: got err=%b imm=%h exp err=1 imm=0", out_err, out_imm); end
        drive_req(IMM_CI, 32'hFFFFFFFF, 5'd7);
        tick();
`ifdef IMM_DECODE_RVC_EN
        n_checks++; if (out_err !== 1'b0 || out_imm !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL sel7_ci: got err=%b imm=%h exp err=0 imm=FFFFFFFF", out_err, out_imm); end
`else
        n_checks++; if (out_err !== 1'b1 || out_imm !== 32'h0) begin n_errors++; $display("FAIL sel7_illegal: got err=%b imm=%h exp err=1 imm=0", out_err, out_imm); end
`endif
        drive_req(IMM_CJ, 32'hFFFFFFFF, 5'd8);
        tick();
`ifdef IMM_DECODE_RVC_EN
        n_checks++; if (out_err !== 1'b0 || out_imm !== 32'hFFFFFFFE) begin n_errors++; $display("FAIL sel8_cj: got err=%b imm=%h exp err=0 imm=FFFFFFFE", out_err, out_imm); end
`else
        n_checks++; if (out_err !== 1'b1 || out_imm !== 32'h0) begin n_errors++; $display("FAIL sel8_illegal: got err=%b imm=%h exp err=1 imm=0", out_err, out_imm); end
`endif
        drive_req(IMM_I, 32'h00000093, 5'd9);
        tick();
        n_checks++; if (out_err !== 1'b0 || out_tag !== 5'd9) begin n_errors++; $display("FAIL err_clears: got err=%b tag=%h exp err=0 tag=09", out_err, out_tag); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_req(IMM_U, 32'hABCDE0B7, 5'd6);
        tick();
        drive_req(IMM_U, 32'h123450B7, 5'd7);
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rm_full: got %b exp 0", in_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== '0) begin n_errors++; $display("FAIL rm_cleared: got v=%b rdy=%b tag=%h exp v=0 rdy=1 tag=00", out_valid, in_ready, out_tag); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rm_stale_%0d: got v=%b tag=%h exp v=0", c, out_valid, out_tag); end
        end
        drive_req(IMM_I, 32'hFFE00093, 5'd11);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_tag !== 5'd11 || out_imm !== 32'hFFFFFFFE) begin n_errors++; $display("FAIL rm_after: got tag=%h imm=%h exp tag=0b imm=FFFFFFFE", out_tag, out_imm); end
        tick();
    endtask

    task automatic test_xlen64();
        logic [31:0] instrs[3] = '{32'hFFF00093, 32'h03F00013, 32'h800000B7};
        imm_sel_t    sels  [3] = '{IMM_I, IMM_SHAMT, IMM_U};
        logic [63:0] exps  [3] = '{64'hFFFFFFFFFFFFFFFF, 64'h000000000000003F, 64'hFFFFFFFF80000000};
        for (int i = 0; i < 3; i++) begin
            d64_in_valid = 1'b1;
            d64_in_sel   = sels[i];
            d64_in_instr = instrs[i];
            d64_in_tag   = TAG_W'(i + 20);
            tick();
            n_checks++;
            if (d64_out_valid !== 1'b1 || d64_out_imm !== exps[i] || d64_out_err !== 1'b0 || d64_out_tag !== TAG_W'(i + 20)) begin
                n_errors++;
                $display("FAIL x64_%0d: got v=%b imm=%h err=%b tag=%h exp imm=%h", i, d64_out_valid, d64_out_imm, d64_out_err, d64_out_tag, exps[i]);
            end
        end
        d64_in_valid = 1'b0;
        tick();
        n_checks++; if (d64_out_valid !== 1'b0 || d64_out_imm !== 64'h0) begin n_errors++; $display("FAIL x64_idle: got v=%b imm=%h exp v=0 imm=0", d64_out_valid, d64_out_imm); end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_instr     = '0;
        in_sel       = IMM_I;
        in_tag       = '0;
        out_ready    = 1'b0;
        d64_in_valid = 1'b0;
        d64_in_instr = '0;
        d64_in_sel   = IMM_I;
        d64_in_tag   = '0;
        #1;
        test_reset();
        test_i_format();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_xlen64();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 5, width of a sideband tag carried unchanged with each immediate (e.g. rd or ROB index).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  stage can accept a request this cycle.
REQ-007 in_instr  input  32  raw instruction word.
REQ-008 in_sel  input  4  immediate format select (encodings in REQ-012).
REQ-009 in_tag  input  TAG_W  sideband tag.
REQ-010 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-011 out_imm  output  XLEN  decoded immediate; out_tag  output  TAG_W; out_err  output  1  illegal in_sel flag.

Function
REQ-012 Formats, all sign-extended from instr[31] to XLEN unless noted: 0 I {instr[31:20]}; 1 S {instr[31:25],instr[11:7]}; 2 B {instr[31],instr[7],instr[30:25],instr[11:8],0}; 3 U {instr[31:12],12'b0}; 4 J {instr[31],instr[19:12],instr[20],instr[30:21],0}; 5 SHAMT zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64); 6 ZIMM zero-extended instr[19:15].
REQ-013 Any in_sel value not enabled as a legal format shall produce out_imm=0 and out_err=1; legal formats shall produce out_err=0.
REQ-014 A request is accepted on a rising edge where in_valid && in_ready; a result is consumed on a rising edge where out_valid && out_ready.
REQ-015 Results are held in a 2-entry in-order buffer; in_ready shall equal (occupancy < 2) and depend only on registered state.
REQ-016 Latency: a request accepted at edge N into an empty buffer shall present out_valid=1 with its result from edge N to edge N+1.
REQ-017 out_imm, out_tag, out_err shall be stable while out_valid=1 and out_ready=0.
REQ-018 Simultaneous accept and consume at occupancy 1 shall leave occupancy 1 with the new entry at the head on the next cycle; at occupancy 2 no accept occurs.
REQ-019 Results shall leave in acceptance order; none dropped or duplicated.
REQ-020 When out_valid=0, out_imm, out_tag and out_err shall be 0.

Reset
REQ-021 While rst_n=0 at a rising edge: occupancy 0, out_valid=0, in_ready=1 from the following cycle, out_imm/out_tag/out_err=0.
REQ-022 Reset mid-operation discards all buffered entries; no partial result is emitted afterwards.

Configuration
REQ-023 Macro IMM_DECODE_RVC_EN: when defined, in_sel 7 = CI sign-extended {instr[12],instr[6:2]} and in_sel 8 = CJ sign-extended {instr[12],instr[8],instr[10:9],instr[6],instr[7],instr[2],instr[11],instr[5:3],0} (12-bit offset) are legal.
REQ-024 When IMM_DECODE_RVC_EN is undefined, in_sel 7 and 8 are illegal per REQ-013; all other behaviour is identical.

Structure
REQ-025 Package imm_pkg shall hold the in_sel encoding constants (IMM_I .. IMM_CJ) and the 4-bit select type; both the block and the bench use it.
REQ-026 Format extraction shall live in a purely combinational sub-module imm_format (instr, sel -> imm, err) instantiated once ahead of the 2-entry buffer.

Verification
REQ-027 XLEN=32, in_sel=I, instr 0xFFF00093, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_err=0.
REQ-028 Sequence S 0xFE20AE23, B 0xFE000EE3, U 0x123450B7, J 0x0080006F back-to-back -> out_imm 0xFFFFFFFC, 0xFFFFFFFC, 0x12345000, 0x00000008 in order, one per cycle.
REQ-029 out_ready=0, three requests tags 1,2,3 -> in_ready=0 after second accept, third held; release out_ready -> tags 1,2,3 emitted in order.
REQ-030 in_sel=4'hF -> out_err=1, out_imm=0; with IMM_DECODE_RVC_EN undefined, in_sel=7 -> out_err=1.
REQ-031 Buffer full, rst_n=0 one edge -> out_valid=0 and in_ready=1 next cycle; no stale tag appears afterwards.
REQ-032 XLEN=64: I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; SHAMT with instr[25:20]=6'h3F -> 0x000000000000003F.
